// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Operand/result handshake bundle between a sequencer and the
//                registered sequential ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
   parameter int WIDTH = 4
) ();
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] result;
   logic             carryout;
   logic             zero;
   logic             negative;
   logic             overflow;
   logic             illegal;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   // Sequencer / writeback side
   modport master (
      output A, B, sel, in_valid, out_ready,
      input  in_ready, result, carryout, zero, negative, overflow,
             illegal, out_valid, busy
   );

   // ALU side
   modport slave (
      input  A, B, sel, in_valid, out_ready,
      output in_ready, result, carryout, zero, negative, overflow,
             illegal, out_valid, busy
   );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered, parametrised ALU with valid/ready handshake,
//                stored carry for ADC/SBB, accumulator and iterative shifts.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
   parameter int WIDTH = 4,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  wire logic clk,
   input  wire logic rst_n,
   alu_seq_if.slave  alu
);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_SHIFT = 2'd1;
   localparam logic [1:0] c_ST_DONE  = 2'd2;

   localparam logic [3:0] c_OP_ADD    = 4'd0;
   localparam logic [3:0] c_OP_SUB    = 4'd1;
   localparam logic [3:0] c_OP_AND    = 4'd2;
   localparam logic [3:0] c_OP_OR     = 4'd3;
   localparam logic [3:0] c_OP_XOR    = 4'd4;
   localparam logic [3:0] c_OP_NOT    = 4'd5;
   localparam logic [3:0] c_OP_INC    = 4'd6;
   localparam logic [3:0] c_OP_DEC    = 4'd7;
   localparam logic [3:0] c_OP_ADC    = 4'd8;
   localparam logic [3:0] c_OP_SBB    = 4'd9;
   localparam logic [3:0] c_OP_SHL    = 4'd10;
   localparam logic [3:0] c_OP_SHR    = 4'd11;
   localparam logic [3:0] c_OP_ACCADD = 4'd12;
   localparam logic [3:0] c_OP_ACCCLR = 4'd13;
   localparam logic [3:0] c_OP_PASS   = 4'd14;

   localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
   localparam logic [SHW-1:0]   c_CNT_ONE = SHW'(1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic             r_zero;
   logic             r_neg;
   logic             r_ovf;
   logic             r_illegal;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_sh;
   logic [SHW-1:0]   r_cnt;
   logic             r_sh_right;

   logic             w_in_ready;
   logic             w_accept;
   logic [SHW-1:0]   w_amt;
   logic             w_shift_multi;
   logic [WIDTH-1:0] w_add_a;
   logic [WIDTH-1:0] w_add_b;
   logic             w_add_cin;
   logic [WIDTH:0]   w_sum;
   logic             w_sum_ovf;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_v;
   logic             w_ill;
   logic             w_acc_we;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0] w_sh_nxt;
   logic             w_sh_out;

   assign w_in_ready    = (r_state == c_ST_IDLE) ||
                          ((r_state == c_ST_DONE) && alu.out_ready);
   assign w_accept      = alu.in_valid && w_in_ready;
   assign w_amt         = alu.B[SHW-1:0];
   // Only nonzero-amount shifts need the iterative path; amt==0 is a plain pass
   assign w_shift_multi = ((alu.sel == c_OP_SHL) || (alu.sel == c_OP_SHR)) &&
                          (w_amt != '0);

   // Adder operand selection: subtract-class ops feed the inverted addend
   always_comb begin
      w_add_a   = alu.A;
      w_add_b   = alu.B;
      w_add_cin = 1'b0;
      case (alu.sel)
         c_OP_SUB:    begin w_add_b = ~alu.B; w_add_cin = 1'b1;    end
         c_OP_INC:    begin w_add_b = c_ONE;                       end
         c_OP_DEC:    begin w_add_b = '1;                          end
         c_OP_ADC:    begin w_add_cin = r_carry;                   end
         c_OP_SBB:    begin w_add_b = ~alu.B; w_add_cin = r_carry; end
         c_OP_ACCADD: begin w_add_a = r_acc; w_add_b = alu.A;     end
         default:     ;
      endcase
   end

   assign w_sum     = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_cin};
   assign w_sum_ovf = (w_add_a[WIDTH-1] == w_add_b[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != w_add_a[WIDTH-1]);

   // Single-cycle result, flags and accumulator update for the accepted op
   always_comb begin
      w_res     = '0;
      w_c       = 1'b0;
      w_v       = 1'b0;
      w_ill     = 1'b0;
      w_acc_we  = 1'b0;
      w_acc_nxt = '0;
      case (alu.sel)
         c_OP_ADD, c_OP_SUB, c_OP_INC, c_OP_DEC, c_OP_ADC, c_OP_SBB: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = w_sum_ovf;
         end
         c_OP_ACCADD: begin
            w_res     = w_sum[WIDTH-1:0];
            w_c       = w_sum[WIDTH];
            w_v       = w_sum_ovf;
            w_acc_we  = 1'b1;
            w_acc_nxt = w_sum[WIDTH-1:0];
         end
         c_OP_AND:    w_res = alu.A & alu.B;
         c_OP_OR:     w_res = alu.A | alu.B;
         c_OP_XOR:    w_res = alu.A ^ alu.B;
         c_OP_NOT:    w_res = ~alu.A;
         c_OP_SHL, c_OP_SHR, c_OP_PASS: w_res = alu.A;
         c_OP_ACCCLR: w_acc_we = 1'b1;
         default:     w_ill = 1'b1;
      endcase
   end

   // One-bit step of the iterative shifter and the bit it pushes out
   assign w_sh_nxt = r_sh_right ? {1'b0, r_sh[WIDTH-1:1]} : {r_sh[WIDTH-2:0], 1'b0};
   assign w_sh_out = r_sh_right ? r_sh[0] : r_sh[WIDTH-1];

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= c_ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (w_accept) w_state_nxt = w_shift_multi ? c_ST_SHIFT : c_ST_DONE;
         end
         c_ST_SHIFT: begin
            if (r_cnt == c_CNT_ONE) w_state_nxt = c_ST_DONE;
         end
         c_ST_DONE: begin
            if (w_accept)           w_state_nxt = w_shift_multi ? c_ST_SHIFT : c_ST_DONE;
            else if (alu.out_ready) w_state_nxt = c_ST_IDLE;
         end
         default: w_state_nxt = c_ST_IDLE;
      endcase
   end

   // FSM outputs: handshake and busy follow the current state
   always_comb begin
      alu.in_ready  = w_in_ready;
      alu.out_valid = (r_state == c_ST_DONE);
      alu.busy      = (r_state == c_ST_SHIFT);
   end

   // Datapath: capture results on accept, step the shifter, commit on last step
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_result   <= '0;
         r_carry    <= 1'b0;
         r_zero     <= 1'b0;
         r_neg      <= 1'b0;
         r_ovf      <= 1'b0;
         r_illegal  <= 1'b0;
         r_acc      <= '0;
         r_sh       <= '0;
         r_cnt      <= '0;
         r_sh_right <= 1'b0;
      end else if (w_accept) begin
         if (w_shift_multi) begin
            r_sh       <= alu.A;
            r_cnt      <= w_amt;
            r_sh_right <= (alu.sel == c_OP_SHR);
         end else begin
            r_result  <= w_res;
            r_carry   <= w_c;
            r_zero    <= (w_res == '0);
            r_neg     <= w_res[WIDTH-1];
            r_ovf     <= w_v;
            r_illegal <= w_ill;
            if (w_acc_we) r_acc <= w_acc_nxt;
         end
      end else if (r_state == c_ST_SHIFT) begin
         r_sh  <= w_sh_nxt;
         r_cnt <= r_cnt - c_CNT_ONE;
         if (r_cnt == c_CNT_ONE) begin
            r_result  <= w_sh_nxt;
            r_carry   <= w_sh_out;
            r_zero    <= (w_sh_nxt == '0);
            r_neg     <= w_sh_nxt[WIDTH-1];
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
         end
      end
   end

   assign alu.result   = r_result;
   assign alu.carryout = r_carry;
   assign alu.zero     = r_zero;
   assign alu.negative = r_neg;
   assign alu.overflow = r_ovf;
   assign alu.illegal  = r_illegal;

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU. Keeps the legacy 8 ops and the A/B/sel/result/carryout/zero naming.
- Adds:
  - WIDTH generalisation
  - valid/ready handshake on input and output
  - registered flags, including a stored carry for chained ADC/SBB
  - an internal accumulator
  - multi-cycle iterative shifts driven by a small FSM
- Sits between a sequencer/register file and writeback. Processes one operation at a time.

Parameters:
- WIDTH, 4: operand/result width. Must be a power of two, ≥4.
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B; for shifts, B[SHW-1:0] is the shift amount
- sel  in  4  opcode
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept an op this cycle
- result  out  WIDTH  registered result
- carryout  out  1  carry flag (registered, also stored internally)
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]
- overflow  out  1  signed overflow (add/sub class only, else 0)
- illegal  out  1  reserved opcode executed
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- busy  out  1  FSM in SHIFT state

Behaviour:
- Reset: synchronous, on rst_n=0 at a clk edge. Effects: state=IDLE; result=0; all flags=0; acc=0; shift counter=0; out_valid=0. Reset wins over every other event, including mid-shift; an aborted op produces no output.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Accept = in_valid && in_ready.
- Operands and sel are captured on accept; later changes to A/B/sel are ignored.
- Single-cycle ops: accepted at edge N, result/flags/out_valid present after edge N+1 (latency 1). Next state is DONE.
- Shift ops (amt = B[SHW-1:0]):
  - amt==0: behaves as a single-cycle op; result=A, carryout=0.
  - amt>0: goes to SHIFT with cnt=amt. Shifts 1 bit per cycle; carryout takes each bit shifted out. When cnt reaches 0, goes to DONE. out_valid is asserted amt+1 cycles after accept.
- DONE:
  - result and flags held stable while out_ready=0.
  - out_ready=1 with no accept: go to IDLE, out_valid=0.
  - out_ready=1 with a simultaneous accept of a single-cycle op: stay DONE, out_valid stays 1 with the new result (throughput 1 op/cycle).
  - out_ready=1 with accept of a shift op with amt>0: go to SHIFT, out_valid=0.
- Opcodes (sum/difference truncated to WIDTH; carryout = adder carry out of bit WIDTH-1):
  - 0 ADD: A+B
  - 1 SUB: A+~B+1 (carry=1 means no borrow)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: ~A, carry 0
  - 6 INC: A+1
  - 7 DEC: A+{WIDTH{1}}
  - 8 ADC: A+B+Cstored
  - 9 SBB: A+~B+Cstored
  - 10 SHL: logical left
  - 11 SHR: logical right
  - 12 ACCADD: acc<=acc+A, result=new acc
  - 13 ACCCLR: acc<=0, result=0
  - 14 PASS: result=A
  - 15 reserved: result=0, illegal=1
- illegal is 0 for every other op.
- Carry for logic ops, PASS and ACCCLR is 0.
- overflow: set for ADD/ADC/INC/ACCADD when both addends have the same sign and the sum sign differs; for SUB/SBB/DEC, computed on the effective addend.
- zero/negative are derived from the new result; all flags update only on op completion.
- Cstored is updated only on op completion and equals the carryout output.
- acc changes only on ACCADD/ACCCLR completion.
- busy=1 exactly during SHIFT cycles; in_ready=0 throughout SHIFT.

Test Plan (WIDTH=8 unless noted):
- WIDTH=4: A=0011, B=0001, sweep sel 0..7 back-to-back with out_ready=1 → results 0100, 0010, 0001, 0011, 0010, 1100, 0100, 0010; one result per cycle; carryout=1 for SUB and DEC.
- ADD 0xFF+0x01 → result 0x00, carryout=1, zero=1. Then ADC 0x00+0x00 → 0x01, carry 0. Then SUB 0x80-0x01 → 0x7F, overflow=1, carry=1.
- SHL A=0x81, B=3 → busy high 3 cycles, in_ready low; out_valid 4 cycles after accept; result=0x08, carryout=0. Repeat with B=1 → 0x02, carry 1. SHR B=0 → 0x81, latency 1.
- Backpressure: complete ADD, hold out_ready=0 for 5 cycles → result/flags/out_valid stable, in_ready=0. Raise out_ready with in_valid high → next op accepted that cycle.
- ACCADD A=0x10 three times → results 0x10, 0x20, 0x30. ACCCLR → 0x00, zero=1. sel=15 → illegal=1, result 0.
- Assert rst_n=0 for one cycle mid-SHIFT → after the edge: out_valid=0, busy=0, in_ready=1, acc=0, flags 0; no stale result appears later.
